// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
// Module   : common_pkg
// Brief    : Shared NoC constants, flit packet type and small helpers.
// Revision : 1.0 - initial release
// ============================================================================
package common_pkg;

  localparam int DEFAULT_VC_W          = 4;
  localparam int DEFAULT_A_W           = 8;
  localparam int DEFAULT_D_W           = 32;
  localparam int DEFAULT_RELAY_DEPTH   = 4;
  localparam int DEFAULT_RELAY_CREDITS = 4;

  // One flit as carried on a NoC link.
  typedef struct packed {
    logic                   last;
    logic [DEFAULT_A_W-1:0] addr;
    logic [DEFAULT_D_W-1:0] data;
  } noc_packet_t;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_if.sv
`default_nettype none
// ============================================================================
// Module   : noc_if
// Brief    : Credit-based NoC link: per-VC flit target, packet, credit grant.
// Revision : 1.0 - initial release
// ============================================================================
interface noc_if
  import common_pkg::*;
#(
  parameter int VC_W = DEFAULT_VC_W
);
  logic [VC_W-1:0] credit_vc_target;
  noc_packet_t     credit_packet;
  logic [VC_W-1:0] credit_vc_credit_gnt;

  modport receiver (
    input  credit_vc_target,
    input  credit_packet,
    output credit_vc_credit_gnt
  );

  modport transmitter (
    output credit_vc_target,
    output credit_packet,
    input  credit_vc_credit_gnt
  );
endinterface
`default_nettype wire

// File: rtl/noc_relay_vc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : noc_relay_vc_fifo
// Brief    : Flop-based FIFO for one virtual channel. Storage is plain
//            registers; pointers wrap modulo DEPTH (any DEPTH >= 1).
//            The caller only pushes when not full (or popping) and only
//            pops when not empty.
// Revision : 1.0 - initial release
// ============================================================================
module noc_relay_vc_fifo
  import common_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flit storage; contents are don't-care while empty so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/noc_credit_relay.sv
`default_nettype none
// ============================================================================
// Module   : noc_credit_relay
// Brief    : Credit-domain splitter for long NoC links. Terminates the
//            upstream credit loop in per-VC flop FIFOs and restarts a new
//            downstream loop through a round-robin arbiter (1 flit/cycle).
//            Optional macro NOC_CREDIT_RELAY_ASSERT_EN compiles in SVA
//            protocol checks; violation handling is the same either way.
// Revision : 1.0 - initial release
// ============================================================================
module noc_credit_relay
  import common_pkg::*;
#(
  parameter int VC_W         = DEFAULT_VC_W,
  parameter int A_W          = DEFAULT_A_W,
  parameter int D_W          = DEFAULT_D_W,
  parameter int DEPTH        = DEFAULT_RELAY_DEPTH,
  parameter int DOWN_CREDITS = DEFAULT_RELAY_CREDITS
)(
  input logic        clk,
  input logic        rst,
  noc_if.receiver    from_tx,
  noc_if.transmitter to_rx
);
  localparam int FLIT_W = 1 + A_W + D_W;
  localparam int RR_W   = clog2_min1(VC_W);
  localparam int CNT_W  = $clog2(DOWN_CREDITS + 1);

  logic [VC_W-1:0]   push;
  logic [VC_W-1:0]   pop;
  logic [VC_W-1:0]   full;
  logic [VC_W-1:0]   empty;
  logic [VC_W-1:0]   eligible;
  logic [FLIT_W-1:0] head [VC_W];
  logic [CNT_W-1:0]  credit_cnt [VC_W];
  logic [RR_W-1:0]   rr;
  logic [RR_W-1:0]   winner;
  logic              grant_valid;
  logic [VC_W-1:0]   sent;
  logic [FLIT_W-1:0] out_flit;

  // A flit aimed at a full FIFO is dropped unless that FIFO drains this cycle.
  assign push = from_tx.credit_vc_target & (~full | pop);

  generate
    for (genvar v = 0; v < VC_W; v++) begin : g_vc
      noc_relay_vc_fifo #(
        .W     (FLIT_W),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push[v]),
        .pop   (pop[v]),
        .din   (from_tx.credit_packet),
        .full  (full[v]),
        .empty (empty[v]),
        .head  (head[v])
      );
      assign eligible[v] = !empty[v] && (credit_cnt[v] != '0);
    end
  endgenerate

  // Round-robin search for the first eligible VC starting at rr.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    winner      = '0;
    for (int i = 0; i < VC_W; i++) begin
      idx = (int'(rr) + i) % VC_W;
      if (!grant_valid && eligible[RR_W'(idx)]) begin
        grant_valid = 1'b1;
        winner      = RR_W'(idx);
      end
    end
  end

  // One-hot pop of the arbitration winner.
  always_comb begin
    pop = '0;
    if (grant_valid) pop[winner] = 1'b1;
  end

  // Registered send strobe (also the upstream credit pulse) and rr pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent <= '0;
      rr   <= '0;
    end else begin
      sent <= pop;
      if (grant_valid)
        rr <= (winner == RR_W'(VC_W - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Output flit register; only meaningful while a target bit is set.
  always_ff @(posedge clk) begin
    if (grant_valid) out_flit <= head[winner];
  end

  // Downstream credit counters: grant adds, send subtracts, both cancel.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_W; v++) begin
      if (rst) begin
        credit_cnt[v] <= CNT_W'(DOWN_CREDITS);
      end else if (to_rx.credit_vc_credit_gnt[v] && !pop[v]) begin
        if (credit_cnt[v] != CNT_W'(DOWN_CREDITS))
          credit_cnt[v] <= credit_cnt[v] + 1'b1;
      end else if (pop[v] && !to_rx.credit_vc_credit_gnt[v]) begin
        credit_cnt[v] <= credit_cnt[v] - 1'b1;
      end
    end
  end

  assign to_rx.credit_vc_target       = sent;
  assign to_rx.credit_packet          = out_flit;
  assign from_tx.credit_vc_credit_gnt = sent;

`ifdef NOC_CREDIT_RELAY_ASSERT_EN
  a_in_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(from_tx.credit_vc_target))
    else $error("noc_credit_relay: multiple upstream VC targets");

  a_out_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(sent))
    else $error("noc_credit_relay: multiple downstream VC targets");

  generate
    for (genvar v = 0; v < VC_W; v++) begin : g_sva
      a_push_full: assert property (@(posedge clk) disable iff (rst)
        !(from_tx.credit_vc_target[v] && full[v] && !pop[v]))
        else $error("noc_credit_relay: push into full FIFO on VC %0d", v);

      a_credit_ovf: assert property (@(posedge clk) disable iff (rst)
        !(to_rx.credit_vc_credit_gnt[v] && !pop[v] &&
          credit_cnt[v] == CNT_W'(DOWN_CREDITS)))
        else $error("noc_credit_relay: credit overflow on VC %0d", v);

      a_send_no_credit: assert property (@(posedge clk) disable iff (rst)
        !(pop[v] && credit_cnt[v] == '0))
        else $error("noc_credit_relay: send without credit on VC %0d", v);
    end
  endgenerate
`else
  // Protocol checks not compiled in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_credit_relay.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_credit_relay
// Brief    : Self-checking bench: queue-based reference model compared every
//            cycle, plus directed scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_credit_relay;
  import common_pkg::*;

  localparam int VC_W  = 2;
  localparam int DEPTH = 4;
  localparam int DC    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  noc_if #(.VC_W(VC_W)) up_if();
  noc_if #(.VC_W(VC_W)) dn_if();

  noc_credit_relay #(
    .VC_W         (VC_W),
    .A_W          (DEFAULT_A_W),
    .D_W          (DEFAULT_D_W),
    .DEPTH        (DEPTH),
    .DOWN_CREDITS (DC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .from_tx (up_if),
    .to_rx   (dn_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queues and credit counts ----------------
  noc_packet_t     mq [VC_W][$];
  int              mcnt [VC_W];
  int              mrr;
  logic [VC_W-1:0] e_target;
  noc_packet_t     e_pkt;
  bit              model_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_W; v++) begin
        mq[v].delete();
        mcnt[v] = DC;
      end
      mrr      = 0;
      e_target = '0;
      model_ok = 1'b1;
    end else begin
      int win;
      win = -1;
      for (int i = 0; i < VC_W; i++) begin
        int v;
        v = (mrr + i) % VC_W;
        if (win < 0 && mq[v].size() > 0 && mcnt[v] > 0) win = v;
      end
      e_target = '0;
      if (win >= 0) begin
        e_pkt         = mq[win].pop_front();
        e_target[win] = 1'b1;
        mrr           = (win + 1) % VC_W;
      end
      for (int v = 0; v < VC_W; v++) begin
        if (dn_if.credit_vc_credit_gnt[v] && !e_target[v])
          mcnt[v] = (mcnt[v] < DC) ? mcnt[v] + 1 : DC;
        else if (!dn_if.credit_vc_credit_gnt[v] && e_target[v])
          mcnt[v] = mcnt[v] - 1;
      end
      for (int v = 0; v < VC_W; v++)
        if (up_if.credit_vc_target[v] && mq[v].size() < DEPTH)
          mq[v].push_back(up_if.credit_packet);
    end
  end

  // ---------------- per-cycle compare and observation logs ----------------
  int              sent0, sent1, up0;
  logic [VC_W-1:0] tlog [$];
  logic [31:0]     dlog [$];

  always @(negedge clk) begin
    if (model_ok) begin
      chk("cyc_target", 64'(dn_if.credit_vc_target), 64'(e_target));
      chk("cyc_up_gnt", 64'(up_if.credit_vc_credit_gnt), 64'(e_target));
      if (e_target != '0) begin
        chk("cyc_addr", 64'(dn_if.credit_packet.addr), 64'(e_pkt.addr));
        chk("cyc_data", 64'(dn_if.credit_packet.data), 64'(e_pkt.data));
        chk("cyc_last", 64'(dn_if.credit_packet.last), 64'(e_pkt.last));
      end
    end
    if (dn_if.credit_vc_target[0]) sent0++;
    if (dn_if.credit_vc_target[1]) sent1++;
    if (up_if.credit_vc_credit_gnt[0]) up0++;
    tlog.push_back(dn_if.credit_vc_target);
    if (dn_if.credit_vc_target != '0) dlog.push_back(dn_if.credit_packet.data);
  end

  // ---------------- stimulus helpers ----------------
  bit auto_ret = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ret) dn_if.credit_vc_credit_gnt = dn_if.credit_vc_target;
  endtask

  task automatic push(input int v, input logic [7:0] a, input logic [31:0] d);
    up_if.credit_vc_target = VC_W'(1 << v);
    up_if.credit_packet    = '{last: 1'b0, addr: a, data: d};
    tick();
    up_if.credit_vc_target = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic clr();
    sent0 = 0; sent1 = 0; up0 = 0;
    tlog.delete();
    dlog.delete();
  endtask

  initial begin
    int          first, last, nz;
    bit          alt;
    logic [1:0]  prev;
    logic [31:0] exp4 [7];

    rst = 1'b1;
    up_if.credit_vc_target     = '0;
    up_if.credit_packet        = '0;
    dn_if.credit_vc_credit_gnt = '0;

    // Reset state and single-flit latency on VC0
    tick();
    do_reset();
    chk("rst_target", 64'(dn_if.credit_vc_target), 64'h0);
    chk("rst_up_gnt", 64'(up_if.credit_vc_credit_gnt), 64'h0);
    push(0, 8'd3, 32'hA5);
    chk("lat_n_plus0", 64'(dn_if.credit_vc_target), 64'h0);
    tick();
    chk("lat_target", 64'(dn_if.credit_vc_target), 64'h1);
    chk("lat_addr", 64'(dn_if.credit_packet.addr), 64'h3);
    chk("lat_data", 64'(dn_if.credit_packet.data), 64'hA5);
    chk("lat_up_gnt", 64'(up_if.credit_vc_credit_gnt), 64'h1);
    tick();
    chk("lat_target_end", 64'(dn_if.credit_vc_target), 64'h0);
    chk("lat_up_gnt_end", 64'(up_if.credit_vc_credit_gnt), 64'h0);
    dn_if.credit_vc_credit_gnt = 2'b01;
    tick();
    dn_if.credit_vc_credit_gnt = '0;

    // Credit starvation on VC1: two sent, two held, one more per returned credit
    clr();
    for (int i = 0; i < 4; i++) push(1, 8'h10, 32'h20 + i);
    for (int i = 0; i < 6; i++) tick();
    chk("starve_sent", 64'(sent1), 64'd2);
    dn_if.credit_vc_credit_gnt = 2'b10;
    tick();
    dn_if.credit_vc_credit_gnt = '0;
    tick();
    chk("starve_resume_target", 64'(dn_if.credit_vc_target), 64'h2);
    chk("starve_resume_data", 64'(dn_if.credit_packet.data), 64'h22);

    // Both VCs backlogged: strict alternation with no idle cycle
    do_reset();
    for (int i = 0; i < 4; i++) push(i % 2, 8'h01, 32'h100 + i);
    for (int i = 0; i < 6; i++) push(i % 2, 8'h02, 32'h200 + i);
    tick();
    clr();
    dn_if.credit_vc_credit_gnt = 2'b11;
    tick();
    dn_if.credit_vc_credit_gnt = '0;
    auto_ret = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    auto_ret = 1'b0;
    dn_if.credit_vc_credit_gnt = '0;
    first = -1; last = -1; nz = 0; alt = 1'b1; prev = '0;
    foreach (tlog[i]) begin
      if (tlog[i] != '0) begin
        if (first < 0) first = i;
        else if (tlog[i] == prev) alt = 1'b0;
        last = i;
        nz++;
        prev = tlog[i];
      end
    end
    chk("alt_count", 64'(nz), 64'd6);
    chk("alt_no_idle", 64'(last - first), 64'd5);
    chk("alt_order", 64'(alt), 64'd1);
    chk("alt_first_vc0", 64'((first >= 0) ? tlog[first] : 2'b00), 64'h1);

    // Full FIFO with simultaneous push and pop keeps all flits
    do_reset();
    clr();
    for (int i = 0; i < 6; i++) push(0, 8'h04, 32'h40 + i);
    tick();
    dn_if.credit_vc_credit_gnt = 2'b01;
    tick();
    dn_if.credit_vc_credit_gnt = '0;
    auto_ret = 1'b1;
    push(0, 8'h04, 32'h88);
    for (int i = 0; i < 10; i++) tick();
    auto_ret = 1'b0;
    dn_if.credit_vc_credit_gnt = '0;
    exp4 = '{32'h40, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45, 32'h88};
    chk("full_sent", 64'(sent0), 64'd7);
    chk("full_up_gnt", 64'(up0), 64'd7);
    chk("full_count", 64'(dlog.size()), 64'd7);
    for (int i = 0; i < 7; i++)
      chk("full_seq", 64'((i < dlog.size()) ? dlog[i] : 32'hFFFF_FFFF), 64'(exp4[i]));

    // Downstream grant in the same cycle as a send at credit 1
    do_reset();
    up_if.credit_packet    = '{last: 1'b0, addr: 8'h05, data: 32'h10};
    up_if.credit_vc_target = 2'b10;
    tick();
    up_if.credit_packet = '{last: 1'b1, addr: 8'h05, data: 32'h11};
    tick();
    up_if.credit_packet = '{last: 1'b0, addr: 8'h05, data: 32'h12};
    dn_if.credit_vc_credit_gnt = 2'b10;
    tick();
    up_if.credit_vc_target     = '0;
    dn_if.credit_vc_credit_gnt = '0;
    tick();
    chk("gnt_send_target", 64'(dn_if.credit_vc_target), 64'h2);
    chk("gnt_send_data", 64'(dn_if.credit_packet.data), 64'h12);

    // Reset with three flits buffered discards them and restores credits
    do_reset();
    for (int i = 0; i < 5; i++) push(0, 8'h06, 32'h60 + i);
    do_reset();
    chk("mid_rst_target", 64'(dn_if.credit_vc_target), 64'h0);
    chk("mid_rst_up_gnt", 64'(up_if.credit_vc_credit_gnt), 64'h0);
    clr();
    for (int i = 0; i < 5; i++) tick();
    chk("mid_rst_no_send", 64'(sent0), 64'd0);
    chk("mid_rst_no_gnt", 64'(up0), 64'd0);
    for (int i = 0; i < 3; i++) push(0, 8'h07, 32'h70 + i);
    for (int i = 0; i < 5; i++) tick();
    chk("mid_rst_credits", 64'(sent0), 64'd2);
    chk("mid_rst_first", 64'((dlog.size() > 0) ? dlog[0] : 32'hFFFF_FFFF), 64'h70);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
